// File: rtl/alu_seq_core.sv
// alu_seq_core: datapath ALU with internal Z/N/C/V status flags.
// Single-cycle ops register their result one edge after start; MUL/MLS run
// an iterative shift-add multiplier for WIDTH cycles and then return
// {result_hi, result}. The FSM state is kept in the named signal state_q.
//
// Handshake: start is only accepted while busy==0 (including the cycle in
// which done is high); every accepted start yields exactly one 1-cycle done
// pulse, and result/result_hi hold their values until the next done.
module alu_seq_core #(
  parameter int  WIDTH = 16,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_INV = 4'h7;
  localparam logic [3:0] OP_TWC = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_LSR = 4'hB;
  localparam logic [3:0] OP_ASR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_MLS = 4'hF;

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, MULT} state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     result_q, result_hi_q;
  logic [3:0]           flags_q;
  logic                 done_q;

  logic                 take_single, load_mul, finish_mul;

  // single-cycle datapath
  logic [WIDTH:0]       a_ext, b_ext, nb_ext, cin_ext;
  logic [WIDTH:0]       alu_sum;
  logic [WIDTH-1:0]     ov_x, ov_y, alu_res;
  logic                 is_arith, is_shift, alu_c, alu_v;
  logic [3:0]           alu_flags;

  // multiplier datapath
  logic [WIDTH:0]       hi_sum;
  logic [2*WIDTH-1:0]   acc_next, prod_final;
  logic [3:0]           mul_flags;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 is_mul_op;

  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  assign nb_ext  = {1'b0, ~b};
  assign cin_ext = {{WIDTH{1'b0}}, flags_q[2]};

  // ALU result in WIDTH+1 bits plus the operand pair used for overflow detection
  always_comb begin
    alu_sum  = '0;
    ov_x     = '0;
    ov_y     = '0;
    is_arith = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_ADD: begin alu_sum = a_ext + b_ext;            ov_x = a; ov_y = b;  is_arith = 1'b1; end
      OP_ADC: begin alu_sum = a_ext + b_ext + cin_ext;  ov_x = a; ov_y = b;  is_arith = 1'b1; end
      OP_SUB: begin alu_sum = a_ext + nb_ext + ONE_EXT; ov_x = a; ov_y = ~b; is_arith = 1'b1; end
      OP_SBC: begin alu_sum = a_ext + nb_ext + cin_ext; ov_x = a; ov_y = ~b; is_arith = 1'b1; end
      OP_AND: alu_sum = {1'b0, a & b};
      OP_OR:  alu_sum = {1'b0, a | b};
      OP_XOR: alu_sum = {1'b0, a ^ b};
      OP_INV: alu_sum = {1'b0, ~b};
      OP_TWC: begin alu_sum = nb_ext + ONE_EXT; ov_x = '0; ov_y = ~b; is_arith = 1'b1; end
      OP_INC: begin alu_sum = b_ext + ONE_EXT;  ov_x = b;  ov_y = '0; is_arith = 1'b1; end
      // DEC is a true WIDTH+1-bit subtraction: bit WIDTH is set only when b wraps from 0
      OP_DEC: begin alu_sum = b_ext - ONE_EXT;  ov_x = b;  ov_y = '1; is_arith = 1'b1; end
      OP_LSR: begin alu_sum = {2'b00, b[WIDTH-1:1]};         is_shift = 1'b1; end
      OP_ASR: begin alu_sum = {1'b0, b[WIDTH-1], b[WIDTH-1:1]}; is_shift = 1'b1; end
      OP_MOV: alu_sum = b_ext;
      default: alu_sum = '0;
    endcase
  end

  assign alu_res   = alu_sum[WIDTH-1:0];
  assign alu_v     = is_arith & (ov_x[WIDTH-1] == ov_y[WIDTH-1]) & (alu_res[WIDTH-1] != ov_x[WIDTH-1]);
  assign alu_c     = is_arith ? alu_sum[WIDTH] : (is_shift ? b[0] : flags_q[2]);
  assign alu_flags = (op == OP_MOV) ? flags_q : {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};

  // operand magnitudes for the signed multiply
  assign is_mul_op = (op == OP_MUL) || (op == OP_MLS);
  assign a_mag     = (op == OP_MLS && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag     = (op == OP_MLS && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

  // one shift-add step: conditionally add multiplicand to the high half, then shift right
  always_comb begin
    hi_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next   = {hi_sum, acc_q[WIDTH-1:1]};
    prod_final = sign_q ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
    mul_flags  = {1'b0, flags_q[2], prod_final[2*WIDTH-1], (prod_final == '0)};
  end

  // next-state and control strobes
  always_comb begin
    state_d     = state_q;
    take_single = 1'b0;
    load_mul    = 1'b0;
    finish_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul_op) begin
            load_mul = 1'b1;
            state_d  = MULT;
          end else begin
            take_single = 1'b1;
          end
        end
      end
      MULT: begin
        if (cnt_q == CNTW'(1)) begin
          finish_mul = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, multiplier and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= take_single | finish_mul;

      if (load_mul) begin
        mcand_q <= a_mag;
        acc_q   <= {{WIDTH{1'b0}}, b_mag};
        sign_q  <= (op == OP_MLS) & (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt_q   <= CNTW'(WIDTH);
      end else if (state_q == MULT) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - CNTW'(1);
      end

      if (take_single) begin
        result_q    <= alu_res;
        result_hi_q <= '0;
      end else if (finish_mul) begin
        result_q    <= prod_final[WIDTH-1:0];
        result_hi_q <= prod_final[2*WIDTH-1:WIDTH];
      end

      // an external flag write overrides any simultaneous ALU flag update
      if (flags_we) begin
        flags_q <= flags_wdata;
      end else if (take_single) begin
        flags_q <= alu_flags;
      end else if (finish_mul) begin
        flags_q <= mul_flags;
      end
    end
  end

  assign busy      = (state_q == MULT);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Testbench for alu_seq_core: a 16-bit instance for the main op table and
// multiplier, plus an 8-bit instance for the narrow-width cases.
module tb_alu_seq_core;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance signals
  logic        start, flags_we, busy, done;
  logic [3:0]  op, flags_wdata, flags;
  logic [15:0] a, b, result, result_hi;

  // 8-bit instance signals
  logic        w8_start, w8_flags_we, w8_busy, w8_done;
  logic [3:0]  w8_op, w8_flags_wdata, w8_flags;
  logic [7:0]  w8_a, w8_b, w8_result, w8_result_hi;

  alu_seq_core #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flags_we(flags_we), .flags_wdata(flags_wdata), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .flags(flags)
  );

  alu_seq_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(w8_start), .op(w8_op), .a(w8_a), .b(w8_b),
    .flags_we(w8_flags_we), .flags_wdata(w8_flags_wdata), .busy(w8_busy), .done(w8_done),
    .result(w8_result), .result_hi(w8_result_hi), .flags(w8_flags)
  );

  // scoreboard: expected {result, result_hi, flags}
  logic [35:0] exp_q[$];
  logic [19:0] exp8_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_done16 = 0;
  int n_done8 = 0;
  int n_issued16 = 0;
  int n_issued8 = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitors: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done16++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb16_unexpected_done: got result %h_%h flags %b, no entry expected", result_hi, result, flags);
      end else begin
        check($sformatf("sb16_%0d", n_done16), {result, result_hi, flags}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && w8_done === 1'b1) begin
      n_done8++;
      if (exp8_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb8_unexpected_done: got result %h_%h flags %b, no entry expected", w8_result_hi, w8_result, w8_flags);
      end else begin
        check($sformatf("sb8_%0d", n_done8), {16'h0, w8_result, w8_result_hi, w8_flags}, {16'h0, exp8_q.pop_front()});
      end
    end
  end

  // driver tasks: present one start for one cycle and queue its expected response
  task automatic issue16(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [15:0] eh, input logic [3:0] ef);
    start = 1'b1; op = o; a = av; b = bv;
    exp_q.push_back({er, eh, ef});
    n_issued16++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic [7:0] eh, input logic [3:0] ef);
    w8_start = 1'b1; w8_op = o; w8_a = av; w8_b = bv;
    exp8_q.push_back({er, eh, ef});
    n_issued8++;
    @(negedge clk);
    w8_start = 1'b0;
  endtask

  task automatic drain16(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check(name, 36'(exp_q.size()), 36'd0);
    exp_q.delete();
  endtask

  task automatic drain8(input string name);
    for (int i = 0; i < 100 && exp8_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check(name, 36'(exp8_q.size()), 36'd0);
    exp8_q.delete();
  endtask

  task automatic write_flags16(input logic [3:0] f);
    flags_we = 1'b1; flags_wdata = f;
    @(negedge clk);
    flags_we = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // main stimulus
  initial begin
    int busy_cycles;
    logic busy_ok;
    rst_n = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0; flags_we = 1'b0; flags_wdata = '0;
    w8_start = 1'b0; w8_op = '0; w8_a = '0; w8_b = '0; w8_flags_we = 1'b0; w8_flags_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 36'(busy), 36'd0);
    check("reset_done", 36'(done), 36'd0);
    check("reset_result", 36'(result), 36'd0);
    check("reset_result_hi", 36'(result_hi), 36'd0);
    check("reset_flags", 36'(flags), 36'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle ops back to back; flags carry through the sequence
    issue16(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0101);
    check("add_latency_done", 36'(done), 36'd1);
    issue16(4'h1, 16'h7FFF, 16'h0001, 16'h8001, 16'h0000, 4'b1010);
    issue16(4'h2, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b1100);
    issue16(4'h3, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0010);
    issue16(4'h3, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'b0100);
    issue16(4'h4, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0110);
    issue16(4'h5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0101);
    issue16(4'h6, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 4'b0110);
    issue16(4'h7, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101);
    issue16(4'h8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0101);
    issue16(4'h8, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 4'b1010);
    issue16(4'h9, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101);
    issue16(4'hA, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0110);
    issue16(4'hA, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 4'b1000);
    issue16(4'hB, 16'h0000, 16'h8001, 16'h4000, 16'h0000, 4'b0100);
    issue16(4'hC, 16'h0000, 16'h8001, 16'hC000, 16'h0000, 4'b0110);
    issue16(4'hD, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0110);
    drain16("drain_single_ops");

    // external flag write alone, then coinciding with an ALU flag update
    write_flags16(4'b0100);
    check("flags_we_write", 36'(flags), 36'b0100);
    issue16(4'h1, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 4'b0000);
    flags_we = 1'b1; flags_wdata = 4'b0010;
    issue16(4'h0, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 4'b0010);
    flags_we = 1'b0;
    drain16("drain_flags_we");

    // signed multiply: C preset to 1 must survive
    write_flags16(4'b0100);
    issue16(4'hF, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 4'b0110);
    busy_cycles = 0; busy_ok = 1'b1;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      busy_cycles++;
      @(negedge clk);
    end
    check("mls_busy_cycles", 36'(busy_cycles), 36'd16);
    check("mls_busy_throughout", 36'(busy_ok), 36'd1);
    check("mls_busy_low_at_done", 36'(busy), 36'd0);

    // unsigned multiply with ignored starts while busy, then a start in the done cycle
    issue16(4'hE, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0110);
    busy_cycles = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      start = (i == 2 || i == 5 || i == 15);
      op = 4'h0; a = 16'h0001; b = 16'h0001;
      busy_cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check("mul_busy_cycles", 36'(busy_cycles), 36'd16);
    issue16(4'h0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 4'b0000);
    drain16("drain_mul");
    check("mul_done_count", 36'(n_done16), 36'(n_issued16));

    // asynchronous reset in the middle of a multiply
    issue16(4'hE, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_issued16--;
    check("rst_mid_mul_busy", 36'(busy), 36'd0);
    check("rst_mid_mul_flags", 36'(flags), 36'd0);
    check("rst_mid_mul_done", 36'(done), 36'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_done", 36'(n_done16), 36'(n_issued16));
    issue16(4'h0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 4'b0000);
    drain16("drain_after_reset");

    // 8-bit instance: arithmetic shift and full-range multiply
    issue8(4'hC, 8'h00, 8'h81, 8'hC0, 8'h00, 4'b0110);
    drain8("drain8_asr");
    issue8(4'hE, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110);
    busy_cycles = 0;
    for (int i = 0; i < 40 && w8_done !== 1'b1; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("mul8_busy_cycles", 36'(busy_cycles), 36'd8);
    drain8("drain8_mul");
    check("mul8_done_count", 36'(n_done8), 36'(n_issued8));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
